// File: rtl/apb_pkg.sv
// Shared types for the APB master slice.
// Width macros can be overridden on the command line. They default to a
// 32-bit address, 32-bit data and 3-bit protection bus.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_PROT_WIDTH
`define APB_PROT_WIDTH 3
`endif

package apb_pkg;

    localparam int unsigned APB_AW = `APB_ADDR_WIDTH;
    localparam int unsigned APB_DW = `APB_DATA_WIDTH;
    localparam int unsigned APB_SW = APB_DW / 8;
    localparam int unsigned APB_PW = `APB_PROT_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // One queued transfer request, in bus-field order.
    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
        logic [APB_SW-1:0] strb;
        logic [APB_PW-1:0] prot;
    } apb_req_t;

endpackage

// File: rtl/apb_req_fifo.sv
// Request buffer for apb_master: a synchronous FIFO of apb_req_t.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   write one request (ignored when full)
//   i_pop            drop the head entry (ignored when empty)
//   o_head           oldest entry
//   o_next           entry behind the head; it becomes the head after a pop
//   o_full, o_empty  occupancy flags, taken from the registered count
//   o_count          number of entries held (log2(DEPTH)+1 bits)
module apb_req_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  apb_req_t               i_data,
    input  logic                   i_pop,
    output apb_req_t               o_head,
    output apb_req_t               o_next,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    apb_req_t        r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   w_rd_next;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_next    = r_mem[w_rd_next];

    // NOTE: the storage array has no reset; the count alone decides which
    // entries are valid, so clearing the data would only cost flops.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= w_rd_next;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB4 master: buffers requester transfers and drives SETUP/ACCESS cycles.
// Ports:
//   PCLK, PRESETn                 clock, asynchronous active-low reset
//   transfer, SWRITE, SADDR,
//   SWDATA, SSTRB, SPROT          request, accepted when SREADY=1
//   SREADY                        request buffer not full
//   SDONE, SRDATA, SERR           one-cycle completion pulse with result
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PSTRB, PPROT          APB request side (all registered)
//   PREADY, PSLVERR, PRDATA       APB slave response
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = `APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = `APB_DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int PROT_WIDTH = `APB_PROT_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  transfer,
    input  logic                  SWRITE,
    input  logic [ADDR_WIDTH-1:0] SADDR,
    input  logic [DATA_WIDTH-1:0] SWDATA,
    input  logic [STRB_WIDTH-1:0] SSTRB,
    input  logic [PROT_WIDTH-1:0] SPROT,
    output logic                  SREADY,
    output logic                  SDONE,
    output logic [DATA_WIDTH-1:0] SRDATA,
    output logic                  SERR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    output logic [PROT_WIDTH-1:0] PPROT,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    apb_state_e            r_state;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_WIDTH-1:0] r_pstrb;
    logic [PROT_WIDTH-1:0] r_pprot;
    logic                  r_sdone;
    logic                  r_serr;
    logic [DATA_WIDTH-1:0] r_srdata;

    apb_req_t              w_push_req;
    apb_req_t              w_head;
    apb_req_t              w_next;
    apb_req_t              w_load;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic                  w_pop;
    logic                  w_more;
    logic                  w_enter_setup;

    assign w_push_req = {SWRITE, SADDR, SWDATA, SSTRB, SPROT};
    assign SREADY     = !w_full;

    // A completing transfer pops the head, so a follow-on SETUP must take the
    // entry behind it. Only entries already queued count: a request pushed on
    // the completing edge is picked up from IDLE on the next cycle.
    assign w_pop         = (r_state == ACCESS) && PREADY;
    assign w_more        = (w_count > CW'(1));
    assign w_load        = (r_state == IDLE) ? w_head : w_next;
    assign w_enter_setup = ((r_state == IDLE) && !w_empty) || (w_pop && w_more);

    apb_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .i_clk   (PCLK),
        .i_rst_n (PRESETn),
        .i_push  (transfer),
        .i_data  (w_push_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pprot   <= '0;
            r_sdone   <= 1'b0;
            r_serr    <= 1'b0;
            r_srdata  <= '0;
        end else begin
            r_sdone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= SETUP;
                        r_psel  <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        r_penable <= 1'b0;
                        r_sdone   <= 1'b1;
                        r_serr    <= PSLVERR;
                        r_srdata  <= r_pwrite ? '0 : PRDATA;
                        if (w_more) begin
                            r_state <= SETUP;
                        end else begin
                            r_state <= IDLE;
                            r_psel  <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Bus fields change only when a SETUP phase begins; they hold
            // through ACCESS and IDLE.
            if (w_enter_setup) begin
                r_pwrite <= w_load.write;
                r_paddr  <= w_load.addr;
                r_pwdata <= w_load.wdata;
                r_pstrb  <= w_load.write ? w_load.strb : '0;
                r_pprot  <= w_load.prot;
            end
        end
    end

    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign PSTRB   = r_pstrb;
    assign PPROT   = r_pprot;
    assign SDONE   = r_sdone;
    assign SERR    = r_serr;
    assign SRDATA  = r_srdata;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int PW    = 3;
    localparam int DEPTH = 2;
    localparam int N_RAND = 300;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          transfer = 1'b0;
    logic          SWRITE = 1'b0;
    logic [AW-1:0] SADDR = '0;
    logic [DW-1:0] SWDATA = '0;
    logic [SW-1:0] SSTRB = '0;
    logic [PW-1:0] SPROT = '0;
    logic          SREADY, SDONE, SERR;
    logic [DW-1:0] SRDATA;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [PW-1:0] PPROT;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;
    logic [DW-1:0] PRDATA = '0;

    always #5 PCLK = ~PCLK;

    apb_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .PROT_WIDTH (PW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .transfer (transfer),
        .SWRITE   (SWRITE),
        .SADDR    (SADDR),
        .SWDATA   (SWDATA),
        .SSTRB    (SSTRB),
        .SPROT    (SPROT),
        .SREADY   (SREADY),
        .SDONE    (SDONE),
        .SRDATA   (SRDATA),
        .SERR     (SERR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PPROT    (PPROT),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .PRDATA   (PRDATA)
    );

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } req_t;

    // Reference model: requests waiting to be offered, requests accepted but
    // not completed (in order), the slave's memory, and the occupancy.
    req_t        stim_q[$];
    req_t        model_q[$];
    logic [31:0] ram [logic [31:0]];
    int          occ = 0;
    bit          exp_done = 0;
    logic [31:0] exp_rdata = '0;
    bit          exp_err = 0;
    int          n_done = 0;

    // Slave behaviour knobs.
    int fixed_waits = 0;
    bit rand_waits  = 0;
    int err_mode    = 0;   // 0 never, 1 random, 2 on address 0xFFC
    int gap_pct     = 0;
    bit in_access   = 0;
    int cur_waits   = 0;
    int wait_cnt    = 0;

    logic          prev_psel = 0, prev_pen = 0, prev_pwrite = 0;
    logic [AW-1:0] prev_paddr = '0;
    logic [DW-1:0] prev_pwdata = '0;
    logic [SW-1:0] prev_pstrb = '0;
    logic [PW-1:0] prev_pprot = '0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic req_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [2:0] p);
        req_t r;
        r.write = w; r.addr = a; r.wdata = d; r.strb = s; r.prot = p;
        return r;
    endfunction

    // One clock cycle: check outputs at the falling edge, then decide the
    // slave response and the next request for the coming rising edge.
    task automatic cycle();
        req_t        r;
        logic [31:0] word;
        @(negedge PCLK);
        if (PRESETn) begin
            check("sdone", SDONE, exp_done);
            if (exp_done) begin
                check("srdata", SRDATA, exp_rdata);
                check("serr", SERR, exp_err);
                n_done++;
            end
            check("sready", SREADY, occ < DEPTH);
            if (PENABLE) check("penable_without_psel", PSEL, 1'b1);
            if (!(PSEL && !PENABLE)) begin
                check("hold_paddr", PADDR, prev_paddr);
                check("hold_pwrite", PWRITE, prev_pwrite);
                check("hold_pwdata", PWDATA, prev_pwdata);
                check("hold_pstrb", PSTRB, prev_pstrb);
                check("hold_pprot", PPROT, prev_pprot);
            end
            if (prev_psel && !prev_pen) check("access_after_setup", {PSEL, PENABLE}, 2'b11);
            if (PSEL && !PWRITE) check("pstrb_read_zero", PSTRB, 0);
            if (PSEL && PENABLE && !in_access) begin
                check("setup_before_access", {prev_psel, prev_pen}, 2'b10);
                if (model_q.size() == 0) begin
                    check("unexpected_access", 1, 0);
                end else begin
                    r = model_q[0];
                    check("paddr", PADDR, r.addr);
                    check("pwrite", PWRITE, r.write);
                    check("pwdata", PWDATA, r.wdata);
                    check("pstrb", PSTRB, r.write ? r.strb : 4'h0);
                    check("pprot", PPROT, r.prot);
                    in_access = 1;
                    wait_cnt  = 0;
                    cur_waits = rand_waits ? int'($urandom_range(0, 2)) : fixed_waits;
                end
            end
        end

        // Slave response for the next rising edge.
        exp_done = 0;
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        PRDATA   = $urandom;
        if (PRESETn && PSEL && PENABLE && in_access) begin
            if (wait_cnt < cur_waits) begin
                wait_cnt++;
            end else begin
                r = model_q.pop_front();
                PREADY  = 1'b1;
                PSLVERR = (err_mode == 1) ? ($urandom_range(0, 3) == 0)
                                          : (err_mode == 2 && r.addr == 32'hFFC);
                word = ram.exists(r.addr) ? ram[r.addr] : 32'h0;
                if (r.write) begin
                    if (!PSLVERR) begin
                        for (int b = 0; b < 4; b++)
                            if (r.strb[b]) word[8*b +: 8] = r.wdata[8*b +: 8];
                        ram[r.addr] = word;
                    end
                    exp_rdata = 32'h0;
                end else begin
                    PRDATA    = word;
                    exp_rdata = word;
                end
                exp_err   = PSLVERR;
                exp_done  = 1;
                occ--;
                in_access = 0;
            end
        end

        // Requester side: offer the head request; it is taken only if ready.
        transfer = 1'b0;
        if (PRESETn && stim_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
            r = stim_q[0];
            transfer = 1'b1;
            SWRITE = r.write; SADDR = r.addr; SWDATA = r.wdata; SSTRB = r.strb; SPROT = r.prot;
            if (SREADY) begin
                model_q.push_back(stim_q.pop_front());
                occ++;
            end
        end else begin
            SWRITE = 1'($urandom); SADDR = $urandom; SWDATA = $urandom;
            SSTRB = 4'($urandom); SPROT = 3'($urandom);
        end

        prev_psel = PSEL; prev_pen = PENABLE; prev_pwrite = PWRITE; prev_paddr = PADDR;
        prev_pwdata = PWDATA; prev_pstrb = PSTRB; prev_pprot = PPROT;
    endtask

    // Run until n completions are seen, collecting bus-shape statistics.
    task automatic run_until_done(input string tag, input int n, output int pen_cycles,
                                  output int psel_cycles, output int psel_drops, output bit sready_low);
        int  dones = 0;
        bit  seen  = 0;
        pen_cycles = 0; psel_cycles = 0; psel_drops = 0; sready_low = 0;
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (!SREADY) sready_low = 1;
            if (SDONE) dones++;
            if (dones == n) break;
            if (seen && !PSEL) psel_drops++;
            if (PSEL) begin seen = 1; psel_cycles++; end
            if (PSEL && PENABLE) pen_cycles++;
        end
        if (dones != n) check({tag, "_timeout"}, dones, n);
    endtask

    int pen, pselc, drops, base, cyc;
    bit low, reached;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while held in reset.
        repeat (2) @(negedge PCLK);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_sdone", SDONE, 0);
        check("rst_serr", SERR, 0);
        check("rst_srdata", SRDATA, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_sready", SREADY, 1);
        PRESETn = 1'b1;

        // Single write, zero wait states: exact phase timing.
        stim_q.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0));
        cycle();
        cycle(); check("t1_idle", {PSEL, PENABLE}, 2'b00);
        cycle(); check("t1_setup", {PSEL, PENABLE}, 2'b10);
        check("t1_paddr", PADDR, 32'h10);
        check("t1_pwdata", PWDATA, 32'hDEADBEEF);
        cycle(); check("t1_access", {PSEL, PENABLE}, 2'b11);
        cycle(); check("t1_sdone", SDONE, 1);
        check("t1_serr", SERR, 0);
        check("t1_idle_after", PSEL, 0);

        // Read with two wait states.
        fixed_waits = 2;
        stim_q.push_back(mk(0, 32'h10, 32'h0, 4'hF, 3'd2));
        run_until_done("t2", 1, pen, pselc, drops, low);
        check("t2_penable_cycles", pen, 3);
        check("t2_srdata", SRDATA, 32'hDEADBEEF);
        check("t2_serr", SERR, 0);

        // Back-to-back writes pushed on consecutive edges.
        fixed_waits = 0;
        stim_q.push_back(mk(1, 32'h0, 32'h11111111, 4'hF, 3'd0));
        stim_q.push_back(mk(1, 32'h4, 32'h22222222, 4'h3, 3'd1));
        stim_q.push_back(mk(1, 32'h8, 32'h33333333, 4'hC, 3'd4));
        run_until_done("t3", 3, pen, pselc, drops, low);
        check("t3_penable_cycles", pen, 3);
        check("t3_psel_cycles", pselc, 6);
        check("t3_psel_drops", drops, 0);
        check("t3_sready_dropped", low, 1);

        // Slave error, then a clean transfer.
        err_mode = 2;
        stim_q.push_back(mk(0, 32'hFFC, 32'h0, 4'hF, 3'd0));
        stim_q.push_back(mk(0, 32'h4, 32'h0, 4'h0, 3'd0));
        run_until_done("t4a", 1, pen, pselc, drops, low);
        check("t4_serr_set", SERR, 1);
        run_until_done("t4b", 1, pen, pselc, drops, low);
        check("t4_serr_clear", SERR, 0);
        check("t4_srdata", SRDATA, 32'h00002222);
        err_mode = 0;

        // Reset during ACCESS with another request queued.
        fixed_waits = 10;
        stim_q.push_back(mk(1, 32'h20, 32'hCAFEF00D, 4'hF, 3'd0));
        stim_q.push_back(mk(0, 32'h24, 32'h0, 4'h0, 3'd0));
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            cycle();
            if (PSEL && PENABLE && occ == 2) reached = 1;
        end
        check("t5_reached_access", reached, 1);
        #2 PRESETn = 1'b0;
        #1;
        check("t5_psel", PSEL, 0);
        check("t5_penable", PENABLE, 0);
        check("t5_sdone", SDONE, 0);
        check("t5_sready", SREADY, 1);
        model_q.delete(); stim_q.delete();
        occ = 0; in_access = 0; exp_done = 0;
        PREADY = 1'b0; transfer = 1'b0;
        prev_psel = 0; prev_pen = 0; prev_pwrite = 0; prev_paddr = '0;
        prev_pwdata = '0; prev_pstrb = '0; prev_pprot = '0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        fixed_waits = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            check("t5_quiet_bus", PSEL, 0);
        end

        // Randomized traffic against the queue/memory model.
        rand_waits = 1; err_mode = 1; gap_pct = 30;
        for (int i = 0; i < N_RAND; i++)
            stim_q.push_back(mk(1'($urandom), {26'd0, 4'($urandom), 2'b00}, $urandom,
                                4'($urandom), 3'($urandom)));
        base = n_done;
        cyc = 0;
        while ((stim_q.size() > 0 || occ > 0) && cyc < 5000) begin
            cycle();
            cyc++;
        end
        check("rand_drained", (stim_q.size() == 0 && occ == 0), 1);
        cycle();
        check("rand_completions", n_done - base, N_RAND);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Bridge between the testbench/system stimulus side and the APB4 bus: it accepts transfer requests (SWRITE, SADDR, SWDATA, SSTRB, SPROT qualified by `transfer`), buffers them in a small request FIFO, and drives the APB4 SETUP/ACCESS protocol (PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT) toward the RAM slave. It returns PRDATA and PSLVERR to the requester with a one-cycle completion pulse. It sits directly upstream of the APB RAM slave.

## Interface
- ADDR_WIDTH, default `APB_ADDR_WIDTH` (32): address width.
- DATA_WIDTH, default `APB_DATA_WIDTH` (32): data width; must be 8, 16 or 32.
- STRB_WIDTH, default DATA_WIDTH/8: byte-strobe width.
- PROT_WIDTH, default `APB_PROT_WIDTH` (3): protection width.
- FIFO_DEPTH, default 2: request buffer entries; power of two, ≥2.

- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETn  in  1  reset, asynchronous assert, active-low.
- transfer  in  1  request valid; accepted on an edge where SREADY=1.
- SWRITE  in  1  1=write, 0=read.
- SADDR  in  ADDR_WIDTH  request address.
- SWDATA  in  DATA_WIDTH  request write data.
- SSTRB  in  STRB_WIDTH  request byte strobes.
- SPROT  in  PROT_WIDTH  request protection.
- SREADY  out  1  FIFO not full; request can be accepted.
- SDONE  out  1  one-cycle pulse: a transfer completed.
- SRDATA  out  DATA_WIDTH  read data of completed transfer (0 for writes).
- SERR  out  1  PSLVERR of completed transfer; valid with SDONE.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  STRB_WIDTH; PPROT  out  PROT_WIDTH.
- PREADY  in  1  slave ready; PSLVERR  in  1  slave error; PRDATA  in  DATA_WIDTH  read data.

## Operation
- Reset: FSM=IDLE, FIFO empty, every output 0 except SREADY=1.
- Push: transfer && SREADY at an edge writes {SWRITE,SADDR,SWDATA,SSTRB,SPROT} into the FIFO. transfer while SREADY=0 is ignored; no error is raised. SREADY = !full and is computed from the pre-edge count; a same-cycle pop does not free a slot.
- FSM states:
  - IDLE: PSEL=0, PENABLE=0. FIFO non-empty → SETUP.
  - SETUP: PSEL=1, PENABLE=0, bus fields from FIFO head. Always → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, fields held stable.
    - PREADY=0: stay in ACCESS.
    - PREADY=1: pop the FIFO and complete. Go to SETUP if the post-pop count > 0 (back-to-back, no IDLE cycle); otherwise go to IDLE.
- Completion: at the edge where ACCESS && PREADY, register SDONE=1, SERR=PSLVERR, and SRDATA = PWRITE ? 0 : PRDATA. SDONE is cleared the following cycle. SRDATA and SERR hold until the next completion.
- PSTRB is driven all-zero for reads, regardless of SSTRB.
- In IDLE, PADDR, PWRITE, PWDATA, PSTRB and PPROT hold their last values.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-transfer: immediate asynchronous return to reset values. Queued and in-flight requests are discarded, with no SDONE.

## Timing
- Request accepted at edge 0 into an empty FIFO while IDLE:
  - SETUP during cycle after edge 1.
  - ACCESS after edge 2.
  - With PREADY=1 sampled at edge 3, SDONE is high during the cycle after edge 3.
  - Minimum latency is 3 edges, plus 1 per wait state.
- Back-to-back: sustained throughput is one transfer per 2 cycles (SETUP+ACCESS) with zero wait states.
- PSEL stays high across consecutive transfers. PENABLE drops for exactly one cycle between them.

## Structure
- Package apb_pkg:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e.
  - packed struct apb_req_t {write, addr, wdata, strb, prot} built from the `APB_*_WIDTH` macros.
- Sub-module apb_req_fifo: a parameterised synchronous FIFO of apb_req_t with full/empty/count and async active-low reset. apb_master instantiates it and holds the FSM and completion registers.

## Test plan
- Single write: SADDR=0x10, SWDATA=0xDEADBEEF, SSTRB=0xF, PREADY tied 1 → SETUP then ACCESS with PADDR=0x10 and PWDATA=0xDEADBEEF; SDONE=1 and SERR=0 at edge 3.
- Read with 2 wait states: SADDR=0x10, slave returns PRDATA=0xDEADBEEF after 2 PREADY=0 cycles → PENABLE held 3 cycles with stable fields; SRDATA=0xDEADBEEF; PSTRB=0 throughout.
- Back-to-back: 3 writes to 0x0, 0x4, 0x8 pushed on consecutive edges → SREADY=0 after 2 pushes (third push retried and accepted later); PSEL never drops; PENABLE pattern 0,1,0,1,0,1; SDONE pulses 3 times.
- Error: slave asserts PSLVERR=1 with PREADY on a read of 0xFFC → SDONE=1 with SERR=1; the next transfer completes with SERR=0.
- Reset mid-ACCESS, with PREADY=0 and one request queued: PRESETn low for 1 cycle → PSEL, PENABLE and SDONE are 0 immediately; SREADY=1; after release, no bus activity until a new transfer.
